fft_frame_scheduler: RTL

- Sequences the FFT core for tone detection: captures NUM_FRAMES evenly spaced frames of FFT_LEN audio samples and streams each into the FFT input.
- Scans each FFT magnitude output frame for its peak bin.
- Reports one (bin, magnitude, frame index) result per frame to the downstream tone-detection FSM.
- Sits between the audio sample source, the FFT core (AXI-stream style valid/ready/last) and the tone-detection logic.

---
 rtl/fft_frame_scheduler.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: captures NUM_FRAMES spaced audio frames into the FFT and reports each frame's peak bin (FFT_DC_REJECT_EN drops bin 0 from the search)
module fft_frame_scheduler #(
  parameter int FFT_LEN    = 1024,
  parameter int NUM_FRAMES = 3,
  parameter int SAMPLE_W   = 16,
  parameter int MAG_W      = 32
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       start_in,
  input  logic [31:0]                frame_gap_in,
  input  logic [SAMPLE_W-1:0]        sample_in,
  input  logic                       sample_valid_in,
  output logic                       sample_ready_out,
  output logic [31:0]                fft_tdata_out,
  output logic                       fft_tvalid_out,
  output logic                       fft_tlast_out,
  input  logic                       fft_tready_in,
  input  logic [MAG_W-1:0]           fft_mag_in,
  input  logic                       fft_mag_valid_in,
  input  logic                       fft_mag_last_in,
  output logic [$clog2(FFT_LEN)-1:0] peak_bin_out,
  output logic [MAG_W-1:0]           peak_mag_out,
  output logic [7:0]                 frame_idx_out,
  output logic                       peak_valid_out,
  output logic                       busy_out,
  output logic                       done_out,
  output logic                       overrun_out,
  output logic                       len_err_out
);
  localparam int BW = $clog2(FFT_LEN);
  localparam logic [BW-1:0] LAST = BW'(FFT_LEN - 1);
  localparam logic [BW-1:0] HALF = BW'(FFT_LEN / 2);
  localparam logic [7:0] LAST_FRAME = 8'(NUM_FRAMES - 1);
  typedef enum logic [2:0] {IDLE, LOAD, COLLECT, REPORT, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] gap_q, gap_cnt_q, gap_cnt_d;
  logic [BW-1:0] smp_cnt_q, bin_cnt_q, pk_bin_q, pk_bin_d, peak_bin_q;
  logic [MAG_W-1:0] pk_mag_q, pk_mag_d, peak_mag_q;
  logic [7:0] frame_q, frame_idx_q;
  logic overrun_q, len_err_q;
  logic beat, first_beat, mag_beat, mag_end, cand, gap_met, gap_late, last_frame;
  logic [15:0] real_w;
  assign real_w     = 16'(signed'(sample_in));
  assign beat       = state_q == LOAD && sample_valid_in && fft_tready_in;
  assign first_beat = beat && smp_cnt_q == '0;
  assign mag_beat   = state_q == COLLECT && fft_mag_valid_in;
  assign mag_end    = mag_beat && fft_mag_last_in;
  assign last_frame = frame_q == LAST_FRAME;
`ifdef FFT_DC_REJECT_EN
  assign cand = mag_beat && bin_cnt_q != '0 && bin_cnt_q < HALF;
`else
  assign cand = mag_beat && bin_cnt_q < HALF;
`endif
  // gap_cnt_q holds cycles elapsed since the frame's first beat, so the beat cycle itself counts as 0
  assign gap_met  = ({1'b0, gap_cnt_q} + 33'd1) >= {1'b0, gap_q};
  assign gap_late = gap_cnt_q >= gap_q;
  // running peak including the current beat; strict compare keeps the lowest bin on ties
  always_comb begin
    pk_mag_d  = (cand && fft_mag_in > pk_mag_q) ? fft_mag_in : pk_mag_q;
    pk_bin_d  = (cand && fft_mag_in > pk_mag_q) ? bin_cnt_q : pk_bin_q;
    gap_cnt_d = first_beat ? 32'd1 : (&gap_cnt_q ? gap_cnt_q : gap_cnt_q + 32'd1);
  end
  // state register
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state_q <= IDLE;
    else state_q <= state_d;
  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_in ? LOAD : IDLE;
      LOAD:    state_d = (beat && smp_cnt_q == LAST) ? COLLECT : LOAD;
      COLLECT: state_d = mag_end ? REPORT : COLLECT;
      REPORT:  state_d = last_frame ? DONE : GAP;
      GAP:     state_d = gap_met ? LOAD : GAP;
      default: state_d = IDLE;
    endcase
  end
  // state-decoded outputs; the FFT input handshake is a combinational pass-through during LOAD
  always_comb begin
    busy_out         = state_q != IDLE && state_q != DONE;
    done_out         = state_q == DONE;
    peak_valid_out   = state_q == REPORT;
    fft_tvalid_out   = state_q == LOAD && sample_valid_in;
    sample_ready_out = state_q == LOAD && fft_tready_in;
    fft_tlast_out    = state_q == LOAD && smp_cnt_q == LAST;
    fft_tdata_out    = state_q == LOAD ? {16'b0, real_w} : 32'b0;
    peak_bin_out     = peak_bin_q;
    peak_mag_out     = peak_mag_q;
    frame_idx_out    = frame_idx_q;
    overrun_out      = overrun_q;
    len_err_out      = len_err_q;
  end
  // counters, peak tracking, result registers and sticky flags
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      smp_cnt_q   <= '0;
      bin_cnt_q   <= '0;
      pk_bin_q    <= '0;
      pk_mag_q    <= '0;
      peak_bin_q  <= '0;
      peak_mag_q  <= '0;
      frame_q     <= '0;
      frame_idx_q <= '0;
      overrun_q   <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && start_in) begin
        gap_q     <= frame_gap_in;
        overrun_q <= 1'b0;
        len_err_q <= 1'b0;
        frame_q   <= '0;
      end
      if (beat) smp_cnt_q <= smp_cnt_q + BW'(1);
      gap_cnt_q <= gap_cnt_d;
      bin_cnt_q <= state_q == LOAD ? '0 : (mag_beat ? bin_cnt_q + BW'(1) : bin_cnt_q);
      pk_mag_q  <= state_q == LOAD ? '0 : pk_mag_d;
      pk_bin_q  <= state_q == LOAD ? '0 : pk_bin_d;
      if (mag_end) begin
        peak_bin_q  <= pk_bin_d;
        peak_mag_q  <= pk_mag_d;
        frame_idx_q <= frame_q;
        if (bin_cnt_q != LAST) len_err_q <= 1'b1;
      end
      if (state_q == REPORT && !last_frame) frame_q <= frame_q + 8'd1;
      if (state_q == GAP && gap_late) overrun_q <= 1'b1;
    end
endmodule
